// File: rtl/axis_soft_mute.sv
// -----------------------------------------------------------------------------
// axis_soft_mute
//
// Click-free stereo mute stage for an AXI-Stream audio path. Both channels of
// a stereo frame are multiplied by one common gain. A mute request ramps the
// gain linearly from unity to zero, one RAMP_STEP per frame. Releasing the
// request ramps it back to unity. A reversal mid-ramp continues from the
// current gain, so the output never jumps. Data passes through one output
// register stage with full backpressure.
//
// Parameters
//   DATA_WIDTH : signed two's-complement sample width
//   GAIN_WIDTH : unsigned gain width, unity = 2^(GAIN_WIDTH-1)
//   RAMP_STEP  : gain change per stereo frame (0 < RAMP_STEP <= unity)
//
// Ports
//   clk            : stream clock
//   rst            : asynchronous, active-high reset
//   mute           : asynchronous level mute request, synchronised internally
//   s_axis_tdata   : input sample
//   s_axis_tvalid  : input valid
//   s_axis_tready  : input ready (combinational, low while rst is high)
//   s_axis_tlast   : high on the right-channel sample, which ends a frame
//   m_axis_tdata   : scaled sample (registered)
//   m_axis_tvalid  : output valid (registered)
//   m_axis_tready  : downstream ready
//   m_axis_tlast   : registered copy of s_axis_tlast
//   muted          : high while the gain sits at zero (MUTED state)
// -----------------------------------------------------------------------------
module axis_soft_mute #(
  parameter int DATA_WIDTH = 24,
  parameter int GAIN_WIDTH = 16,
  parameter int RAMP_STEP  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mute,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  muted
);

  // Product width: signed sample times a non-negative (zero-extended) gain.
  localparam int PROD_WIDTH = DATA_WIDTH + GAIN_WIDTH + 1;

  localparam logic [GAIN_WIDTH-1:0] UNITY     = {1'b1, {(GAIN_WIDTH-1){1'b0}}};
  localparam logic [GAIN_WIDTH-1:0] GAIN_ZERO = {GAIN_WIDTH{1'b0}};
  localparam logic [GAIN_WIDTH-1:0] STEP      = GAIN_WIDTH'(RAMP_STEP);

  // Ramp FSM encoding.
  localparam logic [1:0] ST_UNMUTED   = 2'd0;
  localparam logic [1:0] ST_RAMP_DOWN = 2'd1;
  localparam logic [1:0] ST_MUTED     = 2'd2;
  localparam logic [1:0] ST_RAMP_UP   = 2'd3;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Gain minus one step, clamped at zero.
  function automatic logic [GAIN_WIDTH-1:0] gain_dec(input logic [GAIN_WIDTH-1:0] g);
    logic [GAIN_WIDTH-1:0] res;
    if (g > STEP) begin
      res = g - STEP;
    end else begin
      res = GAIN_ZERO;
    end
    return res;
  endfunction

  // Gain plus one step, clamped at unity. One extra bit keeps the sum exact.
  function automatic logic [GAIN_WIDTH-1:0] gain_inc(input logic [GAIN_WIDTH-1:0] g);
    logic [GAIN_WIDTH:0]   sum;
    logic [GAIN_WIDTH-1:0] res;
    sum = {1'b0, g} + {1'b0, STEP};
    if (sum >= {1'b0, UNITY}) begin
      res = UNITY;
    end else begin
      res = sum[GAIN_WIDTH-1:0];
    end
    return res;
  endfunction

  // Scale a sample by the gain. Taking the product bits from GAIN_WIDTH-1
  // upward is an arithmetic right shift, i.e. rounding toward minus infinity.
  // With g <= unity the kept slice always holds the full result, so there is
  // no overflow and unity gain reproduces the input bit for bit.
  function automatic logic [DATA_WIDTH-1:0] scale_sample(
    input logic [DATA_WIDTH-1:0] d,
    input logic [GAIN_WIDTH-1:0] g
  );
    logic signed [PROD_WIDTH-1:0] prod;
    prod = PROD_WIDTH'($signed(d)) * $signed({1'b0, g});
    return prod[GAIN_WIDTH-1 +: DATA_WIDTH];
  endfunction

  // ---------------------------------------------------------------------------
  // Signals
  // ---------------------------------------------------------------------------
  logic                  mute_meta_q;
  logic                  mute_sync_q;
  logic                  mute_s;

  logic [1:0]            state_q;
  logic [1:0]            state_d;
  logic [GAIN_WIDTH-1:0] gain_q;
  logic [GAIN_WIDTH-1:0] gain_d;
  logic                  muted_q;

  logic [DATA_WIDTH-1:0] tdata_q;
  logic [DATA_WIDTH-1:0] tdata_d;
  logic                  tlast_q;
  logic                  tlast_d;
  logic                  tvalid_q;
  logic                  tvalid_d;

  logic                  ready_s;
  logic                  accept_s;
  logic                  fb_s;
  logic [GAIN_WIDTH-1:0] gain_dn_s;
  logic [GAIN_WIDTH-1:0] gain_up_s;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  // The output register may take a new sample when it is empty or draining
  // this cycle. Ready is forced low while reset is asserted.
  assign ready_s  = ~rst & (~tvalid_q | m_axis_tready);
  assign accept_s = s_axis_tvalid & ready_s;
  // Frame boundary: the right-channel sample is being accepted.
  assign fb_s     = accept_s & s_axis_tlast;

  assign gain_dn_s = gain_dec(gain_q);
  assign gain_up_s = gain_inc(gain_q);
  assign mute_s    = mute_sync_q;

  // Two-flop synchroniser for the asynchronous mute switch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mute_meta_q <= 1'b0;
      mute_sync_q <= 1'b0;
    end else begin
      mute_meta_q <= mute;
      mute_sync_q <= mute_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Gain ramp FSM
  // ---------------------------------------------------------------------------
  // Next gain and state; both move only on a frame boundary so the left and
  // right samples of one frame always see the same gain. Any ramp reverses
  // from the current gain rather than restarting.
  always_comb begin
    state_d = state_q;
    gain_d  = gain_q;
    if (fb_s) begin
      case (state_q)
        ST_UNMUTED: begin
          if (mute_s) begin
            gain_d  = gain_dn_s;
            state_d = (gain_dn_s == GAIN_ZERO) ? ST_MUTED : ST_RAMP_DOWN;
          end else begin
            gain_d  = UNITY;
            state_d = ST_UNMUTED;
          end
        end
        ST_RAMP_DOWN, ST_RAMP_UP: begin
          if (mute_s) begin
            gain_d  = gain_dn_s;
            state_d = (gain_dn_s == GAIN_ZERO) ? ST_MUTED : ST_RAMP_DOWN;
          end else begin
            gain_d  = gain_up_s;
            state_d = (gain_up_s == UNITY) ? ST_UNMUTED : ST_RAMP_UP;
          end
        end
        ST_MUTED: begin
          if (mute_s) begin
            gain_d  = GAIN_ZERO;
            state_d = ST_MUTED;
          end else begin
            gain_d  = STEP;
            state_d = (STEP == UNITY) ? ST_UNMUTED : ST_RAMP_UP;
          end
        end
        default: begin
          // Unreachable encoding: recover to the safe passthrough condition.
          gain_d  = UNITY;
          state_d = ST_UNMUTED;
        end
      endcase
    end else begin
      state_d = state_q;
      gain_d  = gain_q;
    end
  end

  // Ramp state, gain and the muted flag. muted tracks the next state so it
  // changes in the cycle after the frame boundary that enters/leaves MUTED.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_UNMUTED;
      gain_q  <= UNITY;
      muted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gain_q  <= gain_d;
      muted_q <= (state_d == ST_MUTED);
    end
  end

  // ---------------------------------------------------------------------------
  // Output register stage
  // ---------------------------------------------------------------------------
  // Load on accept; otherwise drop valid once the sample has drained, and
  // hold everything stable while the downstream stalls.
  always_comb begin
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    if (accept_s) begin
      tdata_d  = scale_sample(s_axis_tdata, gain_q);
      tlast_d  = s_axis_tlast;
      tvalid_d = 1'b1;
    end else if (m_axis_tready) begin
      tvalid_d = 1'b0;
    end else begin
      tvalid_d = tvalid_q;
    end
  end

  // Output data, last and valid registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tdata_q  <= {DATA_WIDTH{1'b0}};
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign s_axis_tready = ready_s;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign muted         = muted_q;

endmodule

// File: tb/tb_axis_soft_mute.sv
// -----------------------------------------------------------------------------
// Testbench for axis_soft_mute. A driver issues samples and pushes the
// expected output of each accepted sample onto a queue; an independent
// monitor pops and compares whenever an output beat transfers, and also
// checks that stalled output stays stable. The reference gain is a single
// integer: on every accepted tlast it moves one step toward zero (mute) or
// toward unity (no mute), clamped; scaling is floor(sample * g / 32768).
// -----------------------------------------------------------------------------
module tb_axis_soft_mute;

  localparam int DW    = 24;
  localparam int UNITY = 32768;
  localparam int STEP  = 64;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } beat_t;

  logic          clk;
  logic          rst;
  logic          mute;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic          muted;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    g_m     = UNITY;  // reference gain
  int    mute_m  = 0;      // settled mute level as seen by the reference
  int    bp_mode = 0;      // 0: always ready, 1: random, 2: never ready
  beat_t exp_q[$];

  axis_soft_mute #(
    .DATA_WIDTH(24),
    .GAIN_WIDTH(16),
    .RAMP_STEP (64)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mute         (mute),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .s_axis_tlast (s_tlast),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .m_axis_tlast (m_tlast),
    .muted        (muted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Downstream ready pattern, changed shortly after each rising edge.
  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (bp_mode)
        0:       m_tready = 1'b1;
        1:       m_tready = 1'($urandom_range(0, 1));
        default: m_tready = 1'b0;
      endcase
    end
  end

  // floor(d * g / 32768), truncated to the sample width.
  function automatic logic [DW-1:0] exp_scale(input logic [DW-1:0] d, input int g);
    longint prod;
    longint q;
    prod = longint'($signed(d)) * longint'(g);
    q = prod / 32768;
    if (prod < 0 && (prod % 32768) != 0) q = q - 1;
    return q[DW-1:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compares each transferring beat with the scoreboard and checks
  // that a stalled beat does not change.
  initial begin
    logic          stall;
    logic [DW-1:0] hold_d;
    logic          hold_l;
    beat_t         e;
    stall = 1'b0;
    hold_d = '0;
    hold_l = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          n_tests++;
          if (!(m_tvalid === 1'b1 && m_tdata === hold_d && m_tlast === hold_l)) begin
            n_fail++;
            $display("FAIL stall_stable: got v=%0b d=%0h l=%0b, expected v=1 d=%0h l=%0b",
                     m_tvalid, m_tdata, m_tlast, hold_d, hold_l);
          end
        end
        if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_beat: got d=%0h l=%0b, expected no output", m_tdata, m_tlast);
          end else begin
            e = exp_q.pop_front();
            if (m_tdata !== e.d || m_tlast !== e.l) begin
              n_fail++;
              $display("FAIL beat: got d=%0h l=%0b, expected d=%0h l=%0b", m_tdata, m_tlast, e.d, e.l);
            end
          end
        end
        stall  = (m_tvalid === 1'b1) && (m_tready === 1'b0);
        hold_d = m_tdata;
        hold_l = m_tlast;
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accept.
  task automatic send(input logic [DW-1:0] d, input logic l);
    int budget;
    budget = 0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    #1;
    while (s_tready !== 1'b1 && budget < 1000) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (s_tready !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got ready=%0b, expected 1 within 1000 cycles", s_tready);
      s_tvalid = 1'b0;
      return;
    end
    exp_q.push_back('{d: exp_scale(d, g_m), l: l});
    if (l) begin
      if (mute_m != 0) g_m = (g_m > STEP) ? g_m - STEP : 0;
      else             g_m = (g_m + STEP < UNITY) ? g_m + STEP : UNITY;
    end
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [DW-1:0] l_d, input logic [DW-1:0] r_d);
    send(l_d, 1'b0);
    send(r_d, 1'b1);
    s_tvalid = 1'b0;
    chk("muted", {31'd0, muted}, (g_m == 0) ? 32'd1 : 32'd0);
  endtask

  // Change mute with the input idle and let it settle through the synchroniser.
  task automatic set_mute(input logic v);
    s_tvalid = 1'b0;
    mute = v;
    repeat (4) @(negedge clk);
    mute_m = v ? 1 : 0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    s_tvalid = 1'b0;
    while (exp_q.size() != 0 && budget < 2000) begin
      @(negedge clk);
      budget++;
    end
    chk("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    mute = 1'b0;
    s_tdata = '0;
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_s_tready", {31'd0, s_tready}, 32'd0);
    chk("rst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("rst_m_tdata",  {8'd0, m_tdata},  32'd0);
    chk("rst_m_tlast",  {31'd0, m_tlast},  32'd0);
    chk("rst_muted",    {31'd0, muted},    32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Passthrough at unity gain.
    send_frame(24'h123456, 24'hF00001);
    drain();

    // Ramp down on a constant level, with a rounding frame at g = 16384.
    set_mute(1'b1);
    for (int k = 0; k < 256; k++) send_frame(24'h400000, 24'h400000);
    chk("gain_half", g_m, 32'd16384);
    send(24'hFFFFFF, 1'b0);
    send(24'hFFFFFD, 1'b0);
    send(24'h000003, 1'b1);
    s_tvalid = 1'b0;
    for (int k = 0; k < 343; k++) send_frame(24'h400000, 24'h400000);
    drain();
    chk("muted_after_ramp", {31'd0, muted}, 32'd1);

    // Ramp up with random data and random downstream stalls.
    bp_mode = 1;
    set_mute(1'b0);
    for (int k = 0; k < 520; k++) send_frame(DW'($urandom), DW'($urandom));
    drain();
    chk("unmuted_after_up", {31'd0, muted}, 32'd0);

    // Reversal partway through a ramp down.
    set_mute(1'b1);
    for (int k = 0; k < 100; k++) send_frame(DW'($urandom), DW'($urandom));
    set_mute(1'b0);
    for (int k = 0; k < 103; k++) send_frame(DW'($urandom), DW'($urandom));
    drain();

    // Reset in the middle of a ramp with a stalled output sample.
    bp_mode = 0;
    set_mute(1'b1);
    for (int k = 0; k < 200; k++) send_frame(DW'($urandom), DW'($urandom));
    drain();
    bp_mode = 2;
    repeat (2) @(negedge clk);
    send(24'h7ABCDE, 1'b0);
    s_tvalid = 1'b0;
    chk("stalled_valid", {31'd0, m_tvalid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_m_tvalid", {31'd0, m_tvalid}, 32'd0);
    chk("midrst_s_tready", {31'd0, s_tready}, 32'd0);
    chk("midrst_muted",    {31'd0, muted},    32'd0);
    exp_q.delete();
    g_m = UNITY;
    mute = 1'b0;
    mute_m = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    bp_mode = 0;
    repeat (2) @(negedge clk);
    send_frame(24'h654321, 24'h89ABCD);
    drain();
    chk("post_rst_muted", {31'd0, muted}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
